// File: rtl/capture_sequencer_if.sv
// Control/status bundle between the capture sequencer and its surroundings.
// The slave side is the sequencer. The master side drives the camera,
// button and lock inputs and observes the results.
interface capture_sequencer_if;
    logic        i_locked;
    logic        i_cam_done;
    logic        i_vsync;
    logic        i_snap_req;
    logic        i_live_req;
    logic        o_cam_start;
    logic        o_wr_en;
    logic [15:0] o_frame_cnt;
    logic [3:0]  o_state;
    logic        o_err;

    modport master (
        output i_locked, i_cam_done, i_vsync, i_snap_req, i_live_req,
        input  o_cam_start, o_wr_en, o_frame_cnt, o_state, o_err
    );

    modport slave (
        input  i_locked, i_cam_done, i_vsync, i_snap_req, i_live_req,
        output o_cam_start, o_wr_en, o_frame_cnt, o_state, o_err
    );
endinterface

// File: rtl/capture_sequencer.sv
// Camera capture sequencer.
// Waits for clock lock, then waits a power-up delay, then kicks off camera
// register init and waits for it to finish. It then gates frame-buffer
// writes on whole-frame boundaries, which gives a live view and a snapshot
// freeze. All asynchronous inputs are synchronized here, and every
// detected edge is registered. This places a vsync fall at the input
// exactly four clocks ahead of the resulting o_wr_en change.
module capture_sequencer #(
    parameter int unsigned STARTUP_DELAY = 1_000_000,
    parameter int unsigned INIT_TIMEOUT  = 50_000_000
) (
    input  logic               i_top_clk,
    input  logic               w_rst_btn_db,
    capture_sequencer_if.slave bus
);
    localparam int DLY_W = $clog2(STARTUP_DELAY + 1);
    localparam int TO_W  = $clog2(INIT_TIMEOUT + 1);

    typedef enum logic [3:0] {
        WAIT_LOCK = 4'd0,
        PWRUP     = 4'd1,
        START     = 4'd2,
        WAIT_DONE = 4'd3,
        ARM       = 4'd4,
        LIVE      = 4'd5,
        SNAP_PEND = 4'd6,
        FROZEN    = 4'd7,
        ERROR     = 4'd8
    } state_t;

    state_t state, state_n;

    // Bit 0 is the first synchronizer flop and bit 1 the second.
    // Bit 2, where present, holds the previous synchronized sample for edge detect.
    logic [1:0] lock_sync;
    logic [2:0] vs_sync;
    logic [2:0] snap_sync;
    logic [2:0] live_sync;
    logic       vs_fall;
    logic       snap_rise;
    logic       live_rise;
    logic       locked_s;

    logic [DLY_W-1:0] dly_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [15:0]      frame_cnt;
    logic             cam_start;
    logic             wr_en;
    logic             err;

    assign locked_s = lock_sync[1];

    // Synchronize the asynchronous inputs and register the edge pulses.
    always_ff @(posedge i_top_clk or negedge w_rst_btn_db) begin
        if (!w_rst_btn_db) begin
            lock_sync <= '0;
            vs_sync   <= '0;
            snap_sync <= '0;
            live_sync <= '0;
            vs_fall   <= 1'b0;
            snap_rise <= 1'b0;
            live_rise <= 1'b0;
        end else begin
            lock_sync <= {lock_sync[0], bus.i_locked};
            vs_sync   <= {vs_sync[1:0], bus.i_vsync};
            snap_sync <= {snap_sync[1:0], bus.i_snap_req};
            live_sync <= {live_sync[1:0], bus.i_live_req};
            vs_fall   <= vs_sync[2] & ~vs_sync[1];
            snap_rise <= ~snap_sync[2] & snap_sync[1];
            live_rise <= ~live_sync[2] & live_sync[1];
        end
    end

    // Next-state logic. Loss of lock overrides everything except ERROR.
    always_comb begin
        state_n = state;
        unique case (state)
            WAIT_LOCK: if (locked_s) state_n = PWRUP;
            PWRUP:     if (dly_cnt >= DLY_W'(STARTUP_DELAY - 1)) state_n = START;
            START:     state_n = WAIT_DONE;
            WAIT_DONE: begin
                // A completion seen on the timeout cycle still counts as success.
                if (bus.i_cam_done)                         state_n = ARM;
                else if (to_cnt >= TO_W'(INIT_TIMEOUT - 1)) state_n = ERROR;
            end
            ARM:       if (vs_fall)   state_n = LIVE;
            LIVE:      if (snap_rise) state_n = SNAP_PEND;
            SNAP_PEND: if (vs_fall)   state_n = FROZEN;
            FROZEN:    if (live_rise) state_n = ARM;
            ERROR:     state_n = ERROR;
            default:   state_n = WAIT_LOCK;
        endcase
        if (!locked_s && state != ERROR) state_n = WAIT_LOCK;
    end

    // State register, with outputs decoded from the next state so they align with it.
    always_ff @(posedge i_top_clk or negedge w_rst_btn_db) begin
        if (!w_rst_btn_db) begin
            state     <= WAIT_LOCK;
            cam_start <= 1'b0;
            wr_en     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            cam_start <= (state_n == START);
            wr_en     <= (state_n == LIVE) || (state_n == SNAP_PEND);
            err       <= (state_n == ERROR);
        end
    end

    // Delay and timeout counters. Each restarts from zero on entry to its state and saturates.
    always_ff @(posedge i_top_clk or negedge w_rst_btn_db) begin
        if (!w_rst_btn_db) begin
            dly_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (state != PWRUP)
                dly_cnt <= '0;
            else if (dly_cnt != DLY_W'(STARTUP_DELAY))
                dly_cnt <= dly_cnt + 1'b1;

            if (state != WAIT_DONE)
                to_cnt <= '0;
            else if (to_cnt != TO_W'(INIT_TIMEOUT))
                to_cnt <= to_cnt + 1'b1;
        end
    end

    // Count frames that closed while writes were enabled. The count survives lock loss.
    always_ff @(posedge i_top_clk or negedge w_rst_btn_db) begin
        if (!w_rst_btn_db)
            frame_cnt <= '0;
        else if (vs_fall && (state == LIVE || state == SNAP_PEND))
            frame_cnt <= frame_cnt + 16'd1;
    end

    assign bus.o_cam_start = cam_start;
    assign bus.o_wr_en     = wr_en;
    assign bus.o_frame_cnt = frame_cnt;
    assign bus.o_state     = state;
    assign bus.o_err       = err;
endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer (STARTUP_DELAY=10, INIT_TIMEOUT=100).
// The stimulus pushes each expected frame count to a queue, and a monitor
// pops and compares whenever o_frame_cnt moves.
module tb_capture_sequencer;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    capture_sequencer_if cif ();

    capture_sequencer #(
        .STARTUP_DELAY(10),
        .INIT_TIMEOUT (100)
    ) dut (
        .i_top_clk   (clk),
        .w_rst_btn_db(rst_n),
        .bus         (cif.slave)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] cnt_q[$];
    logic [15:0] exp_cnt  = 16'h0;
    logic [15:0] last_cnt = 16'h0;
    int          pulses;
    int          start_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input logic [3:0] s, input int max);
        int i;
        i = 0;
        while (cif.o_state !== s && i < max) begin
            tick(1);
            i++;
        end
        chk(tag, 32'(cif.o_state), 32'(s));
    endtask

    // One full vsync period. The falling edge is the boundary.
    task automatic boundary(input bit counted);
        cif.i_vsync = 1'b1;
        tick(6);
        cif.i_vsync = 1'b0;
        if (counted) begin
            exp_cnt++;
            cnt_q.push_back(32'(exp_cnt));
        end
        tick(6);
    endtask

    task automatic pulse_snap();
        cif.i_snap_req = 1'b1;
        tick(4);
        cif.i_snap_req = 1'b0;
        tick(4);
    endtask

    task automatic pulse_live();
        cif.i_live_req = 1'b1;
        tick(4);
        cif.i_live_req = 1'b0;
        tick(4);
    endtask

    // Scoreboard monitor: every change of o_frame_cnt must match the next queued value.
    always @(negedge clk) begin
        if (!rst_n)
            last_cnt <= 16'h0;
        else if (cif.o_frame_cnt !== last_cnt) begin
            if (cnt_q.size() == 0)
                chk("frame_cnt_unexpected", 32'(cif.o_frame_cnt), 32'(last_cnt));
            else
                chk("frame_cnt_sb", 32'(cif.o_frame_cnt), cnt_q.pop_front());
            last_cnt <= cif.o_frame_cnt;
        end
    end

    initial begin
        rst_n          = 1'b0;
        cif.i_locked   = 1'b0;
        cif.i_cam_done = 1'b0;
        cif.i_vsync    = 1'b0;
        cif.i_snap_req = 1'b0;
        cif.i_live_req = 1'b0;
        #23;
        chk("rst_state",     32'(cif.o_state),     32'd0);
        chk("rst_cam_start", 32'(cif.o_cam_start), 32'd0);
        chk("rst_wr_en",     32'(cif.o_wr_en),     32'd0);
        chk("rst_frame_cnt", 32'(cif.o_frame_cnt), 32'd0);
        chk("rst_err",       32'(cif.o_err),       32'd0);

        // Power-up sequence
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        cif.i_locked = 1'b1;
        tick(3);
        chk("pwrup_entry", 32'(cif.o_state), 32'd1);
        pulses   = 0;
        start_at = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cif.o_cam_start === 1'b1) begin
                pulses++;
                if (start_at < 0) start_at = i;
            end
            if (start_at >= 0 && i == start_at + 20) cif.i_cam_done = 1'b1;
        end
        chk("cam_start_delay",  32'(start_at),        32'd10);
        chk("cam_start_pulses", 32'(pulses),          32'd1);
        chk("arm_state",        32'(cif.o_state),     32'd4);
        chk("arm_wr_en",        32'(cif.o_wr_en),     32'd0);

        // Arm, then go live on a vsync fall
        cif.i_vsync = 1'b1;
        tick(4);
        cif.i_vsync = 1'b0;
        tick(3);
        chk("live_wr_en_3clk", 32'(cif.o_wr_en), 32'd0);
        tick(1);
        chk("live_wr_en_4clk", 32'(cif.o_wr_en), 32'd1);
        chk("live_state",      32'(cif.o_state), 32'd5);
        repeat (3) boundary(1'b1);
        chk("live_frame_cnt3", 32'(cif.o_frame_cnt), 32'd3);

        // Snapshot taken mid-frame
        cif.i_vsync = 1'b1;
        tick(5);
        pulse_snap();
        chk("snap_pend_state", 32'(cif.o_state), 32'd6);
        chk("snap_pend_wr_en", 32'(cif.o_wr_en), 32'd1);
        pulse_live();
        chk("snap_pend_live_ign", 32'(cif.o_state), 32'd6);
        cif.i_vsync = 1'b0;
        exp_cnt++;
        cnt_q.push_back(32'(exp_cnt));
        tick(3);
        chk("snap_wr_en_hold", 32'(cif.o_wr_en), 32'd1);
        tick(1);
        chk("frozen_state",     32'(cif.o_state),     32'd7);
        chk("frozen_wr_en",     32'(cif.o_wr_en),     32'd0);
        chk("frozen_frame_cnt", 32'(cif.o_frame_cnt), 32'd4);
        pulse_snap();
        chk("frozen_snap_ign", 32'(cif.o_state), 32'd7);
        boundary(1'b0);
        chk("frozen_hold", 32'(cif.o_state), 32'd7);
        pulse_live();
        chk("frozen_to_arm", 32'(cif.o_state), 32'd4);
        boundary(1'b0);
        chk("relive_state", 32'(cif.o_state), 32'd5);
        chk("relive_wr_en", 32'(cif.o_wr_en), 32'd1);

        // Lock loss during LIVE with a count of 5
        boundary(1'b1);
        chk("pre_lockloss_cnt", 32'(cif.o_frame_cnt), 32'd5);
        cif.i_locked = 1'b0;
        tick(3);
        chk("lockloss_state", 32'(cif.o_state),     32'd0);
        chk("lockloss_wr_en", 32'(cif.o_wr_en),     32'd0);
        chk("lockloss_cnt",   32'(cif.o_frame_cnt), 32'd5);

        // Relock (i_cam_done still high), then snap coincident with a boundary
        cif.i_locked = 1'b1;
        wait_state("relock_arm", 4'd4, 40);
        boundary(1'b0);
        chk("relock_live", 32'(cif.o_state), 32'd5);
        cif.i_vsync = 1'b1;
        tick(6);
        cif.i_vsync    = 1'b0;
        cif.i_snap_req = 1'b1;
        exp_cnt++;
        cnt_q.push_back(32'(exp_cnt));
        tick(6);
        chk("coincide_state", 32'(cif.o_state),     32'd6);
        chk("coincide_cnt",   32'(cif.o_frame_cnt), 32'd6);
        cif.i_snap_req = 1'b0;
        tick(2);
        boundary(1'b1);
        chk("coincide_frozen", 32'(cif.o_state), 32'd7);
        pulse_live();
        boundary(1'b0);
        chk("wrap_live", 32'(cif.o_state), 32'd5);

        // Wrap from 0xFFFF to 0x0000
        exp_cnt = 16'hFFFF;
        cnt_q.push_back(32'h0000_FFFF);
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        tick(2);
        chk("forced_cnt", 32'(cif.o_frame_cnt), 32'h0000_FFFF);
        boundary(1'b1);
        chk("wrap_cnt", 32'(cif.o_frame_cnt), 32'd0);

        // Asynchronous reset mid-frame
        cif.i_vsync = 1'b1;
        tick(3);
        chk("pre_reset_wr_en", 32'(cif.o_wr_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(cif.o_state),     32'd0);
        chk("async_rst_wr_en", 32'(cif.o_wr_en),     32'd0);
        chk("async_rst_cnt",   32'(cif.o_frame_cnt), 32'd0);
        chk("async_rst_err",   32'(cif.o_err),       32'd0);
        chk("async_rst_start", 32'(cif.o_cam_start), 32'd0);
        cif.i_vsync    = 1'b0;
        cif.i_cam_done = 1'b0;
        exp_cnt        = 16'h0;
        tick(3);

        // Completion arrives on the timeout cycle: done wins
        rst_n = 1'b1;
        wait_state("tie_wait_done", 4'd3, 40);
        tick(99);
        chk("tie_still_waiting", 32'(cif.o_state), 32'd3);
        cif.i_cam_done = 1'b1;
        tick(1);
        chk("tie_done_wins", 32'(cif.o_state), 32'd4);
        chk("tie_no_err",    32'(cif.o_err),   32'd0);
        rst_n          = 1'b0;
        cif.i_cam_done = 1'b0;
        tick(2);

        // Init timeout
        rst_n = 1'b1;
        wait_state("to_wait_done", 4'd3, 40);
        tick(99);
        chk("to_99_cycles", 32'(cif.o_state), 32'd3);
        tick(1);
        chk("to_state", 32'(cif.o_state), 32'd8);
        chk("to_err",   32'(cif.o_err),   32'd1);
        chk("to_wr_en", 32'(cif.o_wr_en), 32'd0);
        cif.i_locked   = 1'b0;
        cif.i_cam_done = 1'b1;
        pulse_snap();
        boundary(1'b0);
        pulse_live();
        chk("err_sticky_state", 32'(cif.o_state), 32'd8);
        chk("err_sticky_err",   32'(cif.o_err),   32'd1);
        chk("err_sticky_wr_en", 32'(cif.o_wr_en), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("err_rst_state", 32'(cif.o_state), 32'd0);
        chk("err_rst_err",   32'(cif.o_err),   32'd0);
        tick(2);

        chk("sb_drained", 32'(cnt_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter STARTUP_DELAY, default 1_000_000, i_top_clk cycles to wait after clock lock before starting camera init.
REQ-002 Parameter INIT_TIMEOUT, default 50_000_000, maximum i_top_clk cycles allowed between o_cam_start and i_cam_done.
REQ-003 i_top_clk  input  1  system clock; all logic is in this domain.
REQ-004 w_rst_btn_db  input  1  reset, asynchronous, active-low.
REQ-005 i_locked  input  1  clock-wizard locked; asynchronous, 2-FF synchronized internally.
REQ-006 i_cam_done  input  1  camera register-init complete, level, i_top_clk domain.
REQ-007 i_vsync  input  1  camera VSYNC, pclk domain; 2-FF synchronized internally.
REQ-008 i_snap_req  input  1  debounced snapshot button, asynchronous level; 2-FF synchronized, rising edge = request.
REQ-009 i_live_req  input  1  debounced resume button, asynchronous level; 2-FF synchronized, rising edge = request.
REQ-010 o_cam_start  output  1  one-cycle pulse that starts camera init.
REQ-011 o_wr_en  output  1  frame-buffer write enable, gates BRAM writes.
REQ-012 o_frame_cnt  output  16  count of frames written to the frame buffer.
REQ-013 o_state  output  4  current state encoding, for debug.
REQ-014 o_err  output  1  camera init timeout, sticky until reset.

Function
REQ-015 The states SHALL be WAIT_LOCK=0, PWRUP=1, START=2, WAIT_DONE=3, ARM=4, LIVE=5, SNAP_PEND=6, FROZEN=7 and ERROR=8; o_state SHALL carry this encoding.
REQ-016 A frame boundary SHALL be a falling edge of synchronized vsync (previous sample 1, current sample 0), detected one cycle after FF2.
REQ-017 Request edges SHALL be detected on the synchronized snap and live levels, one pulse per rising edge.
REQ-018 WAIT_LOCK SHALL go to PWRUP when synchronized locked=1, clearing the delay counter.
REQ-019 PWRUP SHALL go to START after exactly STARTUP_DELAY cycles.
REQ-020 START SHALL last exactly one cycle, assert o_cam_start for that cycle, then go to WAIT_DONE with the timeout counter cleared.
REQ-021 WAIT_DONE SHALL go to ARM when i_cam_done=1.
REQ-022 WAIT_DONE SHALL go to ERROR when the counter reaches INIT_TIMEOUT without i_cam_done=1.
REQ-023 If i_cam_done and the timeout occur in the same cycle, i_cam_done SHALL win.
REQ-024 ARM SHALL go to LIVE on a frame boundary, so writes never start mid-frame.
REQ-025 In LIVE, a snap request SHALL move to SNAP_PEND; live requests are ignored.
REQ-026 SNAP_PEND SHALL go to FROZEN on the next frame boundary, leaving one complete frame in the buffer.
REQ-027 In SNAP_PEND, both snap and live requests SHALL be ignored.
REQ-028 In FROZEN, a live request SHALL move to ARM; snap requests are ignored.
REQ-029 If a snap request and a frame boundary coincide in LIVE, the state SHALL go to SNAP_PEND, not FROZEN, and the boundary SHALL still count.
REQ-030 ERROR SHALL hold o_err=1 and o_wr_en=0 and SHALL exit only through reset.
REQ-031 Synchronized locked=0 in any state except ERROR SHALL force WAIT_LOCK on the next edge, deasserting o_wr_en, with o_frame_cnt retained.
REQ-032 o_wr_en SHALL be a registered decode equal to 1 only in LIVE and SNAP_PEND.
REQ-033 o_wr_en SHALL change on the 4th i_top_clk edge after i_vsync falls at the input.
REQ-034 o_frame_cnt SHALL increment by 1 on each frame boundary that ends a frame while o_wr_en=1 (state LIVE or SNAP_PEND), wrapping from 0xFFFF to 0x0000.
REQ-035 Delay and timeout counters SHALL be sized to hold their parameters and SHALL not wrap.

Reset
REQ-036 While w_rst_btn_db=0, the block SHALL hold state WAIT_LOCK with all synchronizer and edge flops at 0.
REQ-037 While w_rst_btn_db=0, the outputs SHALL be o_cam_start=0, o_wr_en=0, o_frame_cnt=0 and o_err=0.
REQ-038 Reset assertion mid-operation (including during ERROR or LIVE) SHALL take effect immediately, without a clock.
REQ-039 Deassertion SHALL be synchronous to i_top_clk, handled externally.

Verification (STARTUP_DELAY=10, INIT_TIMEOUT=100)
REQ-040 Power-up: assert locked, wait, then raise i_cam_done 20 cycles after start. The bench SHALL see o_cam_start pulse exactly once, 10 cycles after PWRUP entry, followed by state ARM and o_wr_en=0.
REQ-041 Arm/live: in ARM, toggle vsync 1->0. The bench SHALL see o_wr_en=1 four clocks later, and o_frame_cnt=3 after three further boundaries.
REQ-042 Snapshot: in LIVE, pulse snap mid-frame. The bench SHALL see o_wr_en stay 1 until the next boundary, then state FROZEN and o_wr_en=0. A second snap SHALL be ignored, and a live pulse followed by a boundary SHALL return the block to LIVE.
REQ-043 Timeout: never raise i_cam_done. The bench SHALL see state ERROR and o_err=1 after 100 cycles in WAIT_DONE, with both persisting until reset.
REQ-044 Lock loss: drop locked during LIVE with o_frame_cnt=5. The bench SHALL see state WAIT_LOCK and o_wr_en=0 within 3 cycles, with o_frame_cnt=5 retained.
REQ-045 Wrap and reset: force o_frame_cnt=0xFFFF and apply one boundary to read 0x0000, then assert reset mid-frame. All outputs SHALL reach their reset values asynchronously.
